// File: rtl/inst_fetch_pkg.sv
// Shared fetch types: FSM state encoding and the fixed instruction size.
package inst_fetch_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: redirect from execute, instruction memory port, decode handoff.
interface inst_fetch_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] instr_pc;
    logic                  instr_ready;

    modport master (
        input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction queue: circular buffer of {instr, pc}; head reads as zero when empty.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rdata = empty ? '0 : mem[rptr];

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: credit-limited request issue, in-order response queue, and
// redirect flush that drops responses belonging to requests issued before the branch.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input logic          clk,
    input logic          rst,
    inst_fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [DATA_WIDTH-1:0] STEP  = DATA_WIDTH'(INSTR_BYTES);
    localparam logic [DATA_WIDTH-1:0] ALIGN = ~DATA_WIDTH'(INSTR_BYTES - 1);

    fetch_state_t            state, state_nx;
    logic [DATA_WIDTH-1:0]   fpc, rpc, target;
    logic [CW-1:0]           outstanding, out_nx, discard, discard_nx, q_count;
    logic                    credit, grant, push, pop, q_full, q_empty;
    logic [2*DATA_WIDTH-1:0] q_rdata;

    assign target = bus.redirect_pc & ALIGN;

    // Queue slots plus in-flight requests never exceed DEPTH, so every response has room.
    assign credit         = ({1'b0, q_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
    assign bus.imem_req   = (state == RUN) && !bus.redirect && credit;
    assign bus.imem_addr  = fpc & ALIGN;
    assign grant          = bus.imem_req && bus.imem_gnt;
    assign out_nx         = outstanding + CW'(grant) - CW'(bus.imem_rvalid);
    assign push           = bus.imem_rvalid && (state == RUN) && !bus.redirect;
    assign pop            = bus.instr_valid && bus.instr_ready && !bus.redirect;

    assign bus.instr_valid = !q_empty;
    assign bus.instr       = q_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign bus.instr_pc    = q_rdata[DATA_WIDTH-1:0];

    always_comb begin
        state_nx   = state;
        discard_nx = discard;
        case (state)
            IDLE: state_nx = RUN;
            RUN: begin
                if (bus.redirect) begin
                    discard_nx = out_nx;
                    if (out_nx != '0) state_nx = FLUSH;
                end
            end
            FLUSH: begin
                // A second redirect restarts the drain from the live in-flight count.
                if (bus.redirect) begin
                    discard_nx = out_nx;
                    state_nx   = (out_nx != '0) ? FLUSH : RUN;
                end else if (bus.imem_rvalid) begin
                    discard_nx = discard - CW'(1);
                    if (discard == CW'(1)) state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fpc         <= RESET_PC;
            rpc         <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_nx;
            discard     <= discard_nx;
            outstanding <= out_nx;
            if (bus.redirect) begin
                fpc <= target;
                rpc <= target;
            end else begin
                if (grant) fpc <= fpc + STEP;
                if (push)  rpc <= rpc + STEP;
            end
        end
    end

    fetch_queue #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect),
        .push  (push),
        .wdata ({bus.imem_rdata, rpc}),
        .pop   (pop),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    rvalid_has_owner: assert property (@(posedge clk) disable iff (rst)
        bus.imem_rvalid |-> (outstanding != '0));

    queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
        push |-> (!q_full || pop));
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: in-order memory model with programmable latency,
// plus a direct check of the queue's full push+pop and pointer wrap.
module tb_inst_fetch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_if #(.DATA_WIDTH(32)) bus ();

    inst_fetch #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic        q_rst, q_flush, q_push, q_pop, q_full, q_empty;
    logic [15:0] q_wdata, q_rdata;
    logic [2:0]  q_count;

    fetch_queue #(.WIDTH(16), .DEPTH(4)) u_q (
        .clk   (clk),
        .rst   (q_rst),
        .flush (q_flush),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [31:0] a);
        return a ^ 32'h1357_9bdf;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Memory: grants sampled mid-cycle, responses presented in order at +2 after the edge.
    int          lat = 1;
    int          cyc = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] gnt_log[$], pop_pc[$], pop_ins[$];

    initial begin
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.imem_req && bus.imem_gnt) begin
                mq_addr.push_back(bus.imem_addr);
                mq_due.push_back(cyc + lat);
                gnt_log.push_back(bus.imem_addr);
            end
            if (!rst && bus.instr_valid && bus.instr_ready && !bus.redirect) begin
                pop_pc.push_back(bus.instr_pc);
                pop_ins.push_back(bus.instr);
            end
            @(posedge clk);
            if (bus.imem_rvalid) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            #2;
            cyc++;
            if (rst) begin
                mq_addr.delete();
                mq_due.delete();
            end
            if (!rst && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = ins(mq_addr[0]);
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = '0;
            end
        end
    end

    function automatic logic [31:0] gnt_at(input int i);
        return (i < gnt_log.size()) ? gnt_log[i] : 32'hffff_ffff;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        return (i < pop_pc.size()) ? pop_pc[i] : 32'hffff_ffff;
    endfunction

    function automatic logic [31:0] ins_at(input int i);
        return (i < pop_ins.size()) ? pop_ins[i] : 32'hffff_ffff;
    endfunction

    int g0, p0;

    initial begin
        rst = 1'b1;
        q_rst = 1'b1; q_flush = 1'b0; q_push = 1'b0; q_pop = 1'b0; q_wdata = '0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b1;

        // Reset values, then 1-cycle memory: first instr_valid in cycle 3.
        step(2); #2;
        chk("rst_req",   32'(bus.imem_req), 0);
        chk("rst_vld",   32'(bus.instr_valid), 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_pc",    bus.instr_pc, 0);
        step(); rst = 1'b0;
        #2; chk("c0_req", 32'(bus.imem_req), 0); chk("c0_vld", 32'(bus.instr_valid), 0);
        step(); #2; chk("c1_req", 32'(bus.imem_req), 1); chk("c1_addr", bus.imem_addr, 32'h0);
        step(); #2; chk("c2_addr", bus.imem_addr, 32'h4); chk("c2_vld", 32'(bus.instr_valid), 0);
        step(); #2; chk("c3_vld", 32'(bus.instr_valid), 1); chk("c3_pc", bus.instr_pc, 32'h0);
        chk("c3_instr", bus.instr, ins(32'h0));
        step(); #2; chk("c4_pc", bus.instr_pc, 32'h4);
        step(); #2; chk("c5_pc", bus.instr_pc, 32'h8); chk("c5_instr", bus.instr, ins(32'h8));

        // Decode stalled: exactly DEPTH grants, then the queue drains in order.
        bus.instr_ready = 1'b0; rst = 1'b1;
        step(2);
        g0 = gnt_log.size(); p0 = pop_pc.size();
        rst = 1'b0;
        step(12);
        chk("full_gnts", 32'(gnt_log.size() - g0), 4);
        for (int i = 0; i < 4; i++) chk("full_addr", gnt_at(g0 + i), 32'(i * 4));
        #2;
        chk("full_req",  32'(bus.imem_req), 0);
        chk("full_head", bus.instr_pc, 32'h0);
        bus.instr_ready = 1'b1;
        step(6);
        for (int i = 0; i < 4; i++) chk("drain_pc", pop_at(p0 + i), 32'(i * 4));
        chk("drain_ins", ins_at(p0 + 3), ins(32'hc));

        // Queue alone: fill, push+pop while full, drain across the pointer wrap.
        q_rst = 1'b0; q_push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q_wdata = 16'h10 + 16'(i);
            step();
        end
        q_push = 1'b0; #2;
        chk("q_cnt_full", 32'(q_count), 4);
        chk("q_full",     32'(q_full), 1);
        for (int i = 0; i < 3; i++) begin
            q_push = 1'b1; q_pop = 1'b1; q_wdata = 16'h14 + 16'(i);
            chk("q_pp_head", 32'(q_rdata), 32'(16'h10 + 16'(i)));
            chk("q_pp_cnt",  32'(q_count), 4);
            step(); #2;
        end
        q_push = 1'b0;
        chk("q_pp_cnt_end", 32'(q_count), 4);
        for (int i = 0; i < 4; i++) begin
            chk("q_drain", 32'(q_rdata), 32'(16'h13 + 16'(i)));
            step(); #2;
        end
        q_pop = 1'b0;
        chk("q_empty", 32'(q_empty), 1);
        chk("q_cnt_0", 32'(q_count), 0);

        // Latency 3, redirect to 0x100 with three requests in flight.
        lat = 3; bus.instr_ready = 1'b1; rst = 1'b1;
        step(2);
        g0 = gnt_log.size(); p0 = pop_pc.size();
        rst = 1'b0;
        step(4);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
        #2; chk("redir_req", 32'(bus.imem_req), 0);
        step(); bus.redirect = 1'b0;
        #2; chk("flush_vld", 32'(bus.instr_valid), 0); chk("flush_req", 32'(bus.imem_req), 0);
        step(20);
        chk("redir_gnt",  gnt_at(g0 + 3), 32'h100);
        chk("redir_pop0", pop_at(p0), 32'h100);
        chk("redir_ins0", ins_at(p0), ins(32'h100));
        chk("redir_pop1", pop_at(p0 + 1), 32'h104);

        // Misaligned target is forced to a word address.
        bus.redirect = 1'b1; bus.redirect_pc = 32'h103;
        step(); bus.redirect = 1'b0;
        g0 = gnt_log.size(); p0 = pop_pc.size();
        step(20);
        chk("align_gnt",  gnt_at(g0), 32'h100);
        chk("align_pop0", pop_at(p0), 32'h100);
        chk("align_ins0", ins_at(p0), ins(32'h100));
        chk("align_pop1", pop_at(p0 + 1), 32'h104);

        // Back-to-back redirects: the second one wins.
        bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
        step();
        #2; chk("rr_vld", 32'(bus.instr_valid), 0);
        bus.redirect_pc = 32'h300;
        step(); bus.redirect = 1'b0;
        g0 = gnt_log.size(); p0 = pop_pc.size();
        step(20);
        chk("rr_gnt",  gnt_at(g0), 32'h300);
        chk("rr_pop0", pop_at(p0), 32'h300);
        chk("rr_ins0", ins_at(p0), ins(32'h300));

        // Reset with two requests in flight.
        bus.instr_ready = 1'b0;
        step(10);
        bus.instr_ready = 1'b1;
        step(3);
        chk("pre_vld", 32'(bus.instr_valid), 1);
        chk("pre_req", 32'(bus.imem_req), 1);
        rst = 1'b1;
        #2;
        chk("mid_rst_req",   32'(bus.imem_req), 0);
        chk("mid_rst_vld",   32'(bus.instr_valid), 0);
        chk("mid_rst_instr", bus.instr, 0);
        chk("mid_rst_pc",    bus.instr_pc, 0);
        step();
        g0 = gnt_log.size(); p0 = pop_pc.size();
        rst = 1'b0;
        step(12);
        chk("refetch_gnt0", gnt_at(g0), 32'h0);
        chk("refetch_gnt1", gnt_at(g0 + 1), 32'h4);
        chk("refetch_pop0", pop_at(p0), 32'h0);
        chk("refetch_ins0", ins_at(p0), ins(32'h0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction and PC width.
REQ-002 Parameter DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 redirect  input  1  taken branch/jump from execute; flush and refetch.
REQ-007 redirect_pc  input  DATA_WIDTH  target address, sampled when redirect=1.
REQ-008 imem_req  output  1  memory read request valid.
REQ-009 imem_addr  output  DATA_WIDTH  request address, word aligned.
REQ-010 imem_gnt  input  1  memory accepts request this cycle when imem_req=1.
REQ-011 imem_rvalid  input  1  read data returned, in request order, >=1 cycle after grant.
REQ-012 imem_rdata  input  DATA_WIDTH  returned instruction.
REQ-013 instr_valid  output  1  queue head valid to decode.
REQ-014 instr  output  DATA_WIDTH  queue head instruction.
REQ-015 instr_pc  output  DATA_WIDTH  address of queue head instruction.
REQ-016 instr_ready  input  1  decode consumes head when instr_valid=1 and instr_ready=1.

Function
REQ-017 Fetch PC register (fpc) SHALL advance by 4 on each granted request (imem_req & imem_gnt).
REQ-018 imem_addr SHALL equal fpc; imem_addr[1:0] SHALL always be 2'b00.
REQ-019 FSM states IDLE, RUN, FLUSH; IDLE->RUN unconditionally next cycle; RUN->FLUSH on redirect with outstanding>0 after this cycle; FLUSH->RUN when discard count reaches 0.
REQ-020 imem_req SHALL be 1 only in RUN, without redirect this cycle, and when occupancy+outstanding < DEPTH (credit rule; queue never overflows).
REQ-021 Outstanding counter: +1 on grant, -1 on rvalid, both same cycle -> unchanged; width clog2(DEPTH)+1.
REQ-022 Non-discarded rvalid SHALL push {imem_rdata, pc} into the queue; pc tracked by a response-PC register advancing by 4 per push.
REQ-023 Pop occurs on instr_valid & instr_ready; push and pop same cycle SHALL leave occupancy unchanged, including when full.
REQ-024 instr, instr_pc SHALL be registered queue-head values; instr_valid = occupancy!=0; no combinational path from imem_rvalid to instr_valid.
REQ-025 On redirect: queue emptied next cycle (instr_valid=0), fpc and response-PC loaded with {redirect_pc[31:2],2'b00}, discard count loaded with outstanding (plus any grant this cycle, minus any rvalid this cycle).
REQ-026 In FLUSH each rvalid SHALL decrement discard count and SHALL NOT push; no requests issued.
REQ-027 redirect during FLUSH SHALL reload target and recompute discard count per REQ-025; pop in redirect cycle is ignored.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH.
REQ-029 rvalid with outstanding=0 is illegal; behaviour unspecified, assertion required.

Reset
REQ-030 On rst: state=IDLE, fpc=RESET_PC, response-PC=RESET_PC, outstanding=0, discard=0, pointers=0.
REQ-031 During and one cycle after reset: imem_req=0, instr_valid=0, instr=0, instr_pc=0.
REQ-032 Reset asserted mid-fetch SHALL abandon outstanding requests; memory is reset by the same rst.

Structure
REQ-033 Shared package SHALL hold fetch state enum (IDLE, RUN, FLUSH) and constant INSTR_BYTES=4.
REQ-034 Queue SHALL be sub-module fetch_queue (DEPTH x 2*DATA_WIDTH, push/pop, full/empty/count); FSM and credit logic in inst_fetch.
REQ-035 Block sits between pcreg-style PC source and controltop; replaces direct PC-to-decode path.

Verification
REQ-036 Reset, memory 1-cycle latency, instr_ready=1 -> imem_addr 0,4,8,...; first instr_valid at cycle 3 after rst release, instr_pc 0,4,8 consecutive.
REQ-037 instr_ready=0 for 10 cycles -> exactly DEPTH=4 grants, then imem_req=0; queue holds PCs 0..12 in order.
REQ-038 3 outstanding, latency 3, redirect_pc=0x100 -> 3 responses discarded, next instr_pc=0x100, no stale instruction delivered.
REQ-039 redirect_pc=0x103 -> imem_addr=0x100.
REQ-040 Full queue with simultaneous push and pop -> count stays 4, order preserved across pointer wrap.
REQ-041 rst asserted with 2 requests in flight -> all outputs at reset values same cycle; refetch from RESET_PC.
